cntr_pwm_gen: RTL and testbench
===============================

CNTR_PWM_GEN -- requirements
Module: cntr_pwm_gen

Interface
REQ-001 Parameter: CNT_W, 8, width of the incoming count and of the duty value.
REQ-002 Parameter: PER_W, 8, width of the completed-period counter.
REQ-003 Port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: start  in  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 Port: en  in  1  run enable; low forces IDLE.
REQ-006 Port: count  in  CNT_W  free-running up-count from the upstream counter stage, wrapping 2^CNT_W-1 -> 0.
REQ-007 Port: cfg_valid  in  1  new duty offered.
REQ-008 Port: cfg_duty  in  CNT_W  offered duty value, high-time in count steps.
REQ-009 Port: cfg_ready  out  1  block can accept cfg_duty this cycle.
REQ-010 Port: pwm  out  1  registered PWM output.
REQ-011 Port: wrap  out  1  registered one-cycle pulse marking a count wrap.
REQ-012 Port: periods  out  PER_W  completed wraps while running, saturating.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, RUN and PEND (config held awaiting wrap).
REQ-014 IDLE->RUN SHALL occur on the edge where en=1. RUN->PEND SHALL occur on a config transfer. PEND->RUN SHALL occur on a wrap event. Any state SHALL go to IDLE on the edge where en=0.
REQ-015 A config transfer SHALL occur on an edge where cfg_valid=1 and cfg_ready=1.
REQ-016 cfg_ready SHALL be combinational: 1 in IDLE and RUN, 0 in PEND.
REQ-017 A transfer in IDLE SHALL write cfg_duty directly into duty_active and leave the state at IDLE, unless en=1 on that same edge, in which case the state SHALL move to RUN.
REQ-018 A transfer in RUN SHALL write cfg_duty into duty_pend only; duty_active SHALL remain unchanged until the next wrap event.
REQ-019 prev SHALL register count on every edge.
REQ-020 A wrap event SHALL be an edge in RUN or PEND where count < prev. The IDLE->RUN edge SHALL never be a wrap event.
REQ-021 On a wrap event in PEND, duty_active SHALL take duty_pend on that same edge.
REQ-022 On every edge, pwm SHALL take (state_next != IDLE) and (count < duty_next), where duty_next is the duty_active value written on that edge. The new duty therefore governs the first sample of the new period.
REQ-023 duty=0 SHALL yield pwm constantly 0. duty=2^CNT_W-1 SHALL yield pwm high for every count except 2^CNT_W-1.
REQ-024 wrap SHALL be 1 for exactly the edge following each wrap event and 0 otherwise.
REQ-025 periods SHALL increment by 1 on each wrap event, SHALL hold at 2^PER_W-1 (no wrap-around), and SHALL hold its value in IDLE.
REQ-026 Entry to IDLE via en=0 SHALL discard duty_pend, and pwm and wrap SHALL be 0 on that edge.
REQ-027 Output latency from count to pwm SHALL be one cycle.

Reset
REQ-028 While start=1 at a rising edge, the block SHALL set: state=IDLE, duty_active=0, duty_pend=0, prev=0, pwm=0, wrap=0, periods=0.
REQ-029 start SHALL take priority over en and cfg_valid on the same edge.
REQ-030 A reset asserted mid-operation, including in PEND, SHALL abandon the pending config.
REQ-031 cfg_ready SHALL be 1 on the first cycle after reset.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE, RUN, PEND) and the default CNT_W/PER_W constants shared with the counter stage.
REQ-033 Wrap detection (the prev register and the compare) SHALL be one sub-module, cntr_wrap_det.
REQ-034 The bench SHALL instantiate upcntr driving count, with its start tied to this block's start.

Verification
REQ-035 Reset/idle: start=1 for 2 cycles, then en=0 -> pwm=0, wrap=0, periods=0, cfg_ready=1.
REQ-036 IDLE config: cfg_duty=64 accepted in IDLE, then en=1 -> pwm=1 one cycle after count in 0..63, pwm=0 for count 64..255.
REQ-037 Deferred update: running with duty=64, transfer duty=192 at count=100 -> cfg_ready=0, pwm stays low until wrap; from count=0 pwm is high through count 191.
REQ-038 Extremes: duty=0 -> pwm never high over 512 cycles; duty=255 -> pwm low only on the sample following count=255.
REQ-039 Periods: 300 wraps -> periods=255 held, and wrap pulses exactly once per 256 cycles.
REQ-040 Mid-operation abort: start=1 or en=0 while in PEND -> state IDLE, duty_pend discarded, next wrap does not change duty_active.

Source files
------------

// File: rtl/cntr_pwm_gen_pkg.sv
// Types and width defaults shared by the PWM generator and the up-counter stage
// that feeds it.
package cntr_pwm_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int PER_W_DEF = 8;

endpackage

// File: rtl/cntr_wrap_det.sv
// Wrap detector: remembers the previous count and flags an edge where the
// count went backwards while the generator is armed.
module cntr_wrap_det
    import cntr_pwm_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             armed,
    output logic             wrap_evt
);

    logic [CNT_W-1:0] prev;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (start) begin
            prev <= '0;
        end else begin
            prev <= count;
        end
    end

    // Not armed on the IDLE->RUN edge, so a stale prev never fakes a wrap.
    assign wrap_evt = armed && (count < prev);

endmodule

// File: rtl/upcntr.sv
// Free-running up-counter stage whose count feeds the PWM generator.
// It wraps naturally from all-ones back to zero.
module upcntr
    import cntr_pwm_gen_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         start,
    output logic [W-1:0] count
);

    // NOTE: reset is synchronous and active-high, so it is tested inside the
    // clocked block rather than listed in the sensitivity list.
    always_ff @(posedge clock) begin
        if (start) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cntr_pwm_gen.sv
// PWM generator driven by an external up-count. A new duty offered while
// running is held until the next count wrap so periods never tear.
module cntr_pwm_gen
    import cntr_pwm_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clock,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] count,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             cfg_ready,
    output logic             pwm,
    output logic             wrap,
    output logic [PER_W-1:0] periods
);

    state_t           state, state_next;
    logic [CNT_W-1:0] duty_active, duty_next;
    logic [CNT_W-1:0] duty_pend, pend_next;
    logic             xfer;
    logic             armed;
    logic             wrap_evt;

    assign xfer  = cfg_valid && cfg_ready;
    assign armed = en && (state != IDLE);

    cntr_wrap_det #(.CNT_W(CNT_W)) u_wrap_det (
        .clock    (clock),
        .start    (start),
        .count    (count),
        .armed    (armed),
        .wrap_evt (wrap_evt)
    );

    always_ff @(posedge clock) begin
        if (start) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = RUN;
                RUN:     if (xfer)     state_next = PEND;
                PEND:    if (wrap_evt) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state != PEND);
        duty_next = duty_active;
        pend_next = duty_pend;
        if (state == IDLE && xfer) begin
            duty_next = cfg_duty;
        end else if (state == PEND && wrap_evt) begin
            duty_next = duty_pend;
        end
        if (state == RUN && xfer) begin
            pend_next = cfg_duty;
        end
        // Dropping out of the run discards any held config.
        if (state_next == IDLE) begin
            pend_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            duty_active <= '0;
            duty_pend   <= '0;
            pwm         <= 1'b0;
            wrap        <= 1'b0;
            periods     <= '0;
        end else begin
            duty_active <= duty_next;
            duty_pend   <= pend_next;
            pwm         <= (state_next != IDLE) && (count < duty_next);
            wrap        <= wrap_evt;
            if (wrap_evt && (periods != {PER_W{1'b1}})) begin
                periods <= periods + PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cntr_pwm_gen.sv
// Directed bench for cntr_pwm_gen fed by upcntr; a cycle model pushes
// expected outputs to a scoreboard that is popped after each edge.
module tb_cntr_pwm_gen;

    logic       clock = 1'b0;
    logic       start = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_duty = 8'd0;
    logic [7:0] count;
    logic       cfg_ready, pwm, wrap;
    logic [7:0] periods;

    logic       en_s = 1'b0;
    logic [3:0] count_s;
    logic       cfg_ready_s, pwm_s, wrap_s;
    logic [7:0] periods_s;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    upcntr #(.W(8)) u_cnt (.clock(clock), .start(start), .count(count));

    cntr_pwm_gen #(.CNT_W(8), .PER_W(8)) dut (
        .clock(clock), .start(start), .en(en), .count(count),
        .cfg_valid(cfg_valid), .cfg_duty(cfg_duty), .cfg_ready(cfg_ready),
        .pwm(pwm), .wrap(wrap), .periods(periods)
    );

    upcntr #(.W(4)) u_cnt_s (.clock(clock), .start(start), .count(count_s));

    cntr_pwm_gen #(.CNT_W(4), .PER_W(8)) dut_s (
        .clock(clock), .start(start), .en(en_s), .count(count_s),
        .cfg_valid(1'b0), .cfg_duty(4'd0), .cfg_ready(cfg_ready_s),
        .pwm(pwm_s), .wrap(wrap_s), .periods(periods_s)
    );

    typedef struct {
        logic       pwm;
        logic       wrap;
        logic [7:0] periods;
    } exp_t;

    exp_t sb[$];

    // Reference model: 0 idle, 1 running, 2 running with a held duty.
    int         m_st = 0;
    logic [7:0] m_duty = 0, m_pduty = 0, m_prev = 0;
    int         m_per = 0;
    int         pwm_hi = 0, pwm_lo = 0;

    task automatic step();
        exp_t       e;
        logic [7:0] c;
        logic       xfer, wev;
        c = count;
        total++;
        assert (cfg_ready === (m_st != 2))
        else begin
            bad++;
            $error("FAIL cfg_ready: got %b want %b", cfg_ready, (m_st != 2));
        end
        if (start) begin
            m_st = 0; m_duty = 0; m_pduty = 0; m_per = 0;
            e.pwm = 0; e.wrap = 0;
        end else begin
            xfer = cfg_valid && (m_st != 2);
            wev  = (m_st != 0) && en && (c < m_prev);
            if (!en) begin
                if (m_st == 0 && xfer) m_duty = cfg_duty;
                m_st = 0;
                m_pduty = 0;
            end else if (m_st == 0) begin
                if (xfer) m_duty = cfg_duty;
                m_st = 1;
            end else if (m_st == 1) begin
                if (xfer) begin
                    m_pduty = cfg_duty;
                    m_st = 2;
                end
            end else if (wev) begin
                m_duty = m_pduty;
                m_st = 1;
            end
            if (wev && m_per < 255) m_per++;
            e.pwm  = (m_st != 0) && (c < m_duty);
            e.wrap = wev;
        end
        e.periods = 8'(m_per);
        m_prev = start ? 8'd0 : c;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        e = sb.pop_front();
        if (pwm === 1'b1) pwm_hi++;
        if (pwm === 1'b0) pwm_lo++;
        total++;
        assert (pwm === e.pwm)
        else begin
            bad++;
            $error("FAIL pwm: got %b want %b (count before edge %0d)", pwm, e.pwm, c);
        end
        total++;
        assert (wrap === e.wrap)
        else begin
            bad++;
            $error("FAIL wrap: got %b want %b (count before edge %0d)", wrap, e.wrap, c);
        end
        total++;
        assert (periods === e.periods)
        else begin
            bad++;
            $error("FAIL periods: got %0d want %0d", periods, e.periods);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [7:0] d);
        cfg_duty  = d;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_count(input logic [7:0] v);
        int g = 0;
        while (count !== v && g < 300) begin
            step();
            g++;
        end
        total++;
        assert (g < 300)
        else begin
            bad++;
            $error("FAIL wait_count: got timeout after %0d want count %0d", g, v);
        end
    endtask

    task automatic expect_window(input string tag, input int n, input int hi_want);
        pwm_hi = 0;
        run(n);
        total++;
        assert (pwm_hi == hi_want)
        else begin
            bad++;
            $error("FAIL %s: got %0d high samples want %0d", tag, pwm_hi, hi_want);
        end
    endtask

    initial begin
        int n_wrap, last, cyc;

        @(posedge clock);
        @(negedge clock);
        // Reset and idle.
        start = 1'b1;
        run(2);
        start = 1'b0;
        run(3);

        // Duty loaded in IDLE, then enabled.
        offer(8'd64);
        en = 1'b1;
        run(300);
        expect_window("duty64_window", 256, 64);

        // Deferred update at count 100.
        wait_count(8'd100);
        offer(8'd192);
        run(400);
        expect_window("duty192_window", 256, 192);

        // Extremes.
        offer(8'd0);
        run(300);
        expect_window("duty0_window", 512, 0);
        offer(8'd255);
        run(300);
        expect_window("duty255_window", 512, 510);

        // Abort from PEND via en=0.
        offer(8'd64);
        run(300);
        wait_count(8'd10);
        offer(8'd192);
        en = 1'b0;
        step();
        en = 1'b1;
        run(300);
        expect_window("abort_en_window", 256, 64);

        // Abort from PEND via start.
        wait_count(8'd20);
        offer(8'd192);
        start = 1'b1;
        step();
        start = 1'b0;
        run(300);
        expect_window("abort_start_window", 256, 0);
        en = 1'b0;
        run(2);

        // Period saturation on a narrow 16-step counter instance.
        en_s = 1'b1;
        n_wrap = 0;
        last = -1;
        for (cyc = 0; cyc < 300 * 16 + 40; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            if (wrap_s === 1'b1) begin
                n_wrap++;
                if (last >= 0) begin
                    total++;
                    assert (cyc - last == 16)
                    else begin
                        bad++;
                        $error("FAIL wrap_spacing: got %0d want 16", cyc - last);
                    end
                end
                last = cyc;
                total++;
                assert (periods_s === 8'((n_wrap > 255) ? 255 : n_wrap))
                else begin
                    bad++;
                    $error("FAIL periods_count: got %0d want %0d", periods_s, (n_wrap > 255) ? 255 : n_wrap);
                end
            end
        end
        total++;
        assert (n_wrap >= 300 && periods_s === 8'd255)
        else begin
            bad++;
            $error("FAIL periods_sat: got %0d wraps periods %0d want >=300 and 255", n_wrap, periods_s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
